// File: rtl/sid_pkg.sv
// Shared constants and types for the tt_um_sid audio output stage.
package sid_pkg;

  localparam int unsigned SID_IN_W     = 16;
  localparam int unsigned SID_PWM_BITS = 8;
  localparam logic [SID_IN_W-1:0] SID_MIDSCALE = {1'b1, {(SID_IN_W-1){1'b0}}};

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } mul_state_t;

endpackage

// File: rtl/sid_pwm_core.sv
// PWM carrier counter with first-order error feedback; the duty is reloaded
// from the held sample at the start of each carrier period.
module sid_pwm_core
  import sid_pkg::*;
#(
  parameter int unsigned IN_W     = SID_IN_W,
  parameter int unsigned PWM_BITS = SID_PWM_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [IN_W-1:0] hold,
  output logic            pwm_out,
  output logic            period_start
);

  localparam int unsigned ERR_W = IN_W - PWM_BITS;
  localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};

  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_eff;
  logic [ERR_W-1:0]    err;
  logic [ERR_W-1:0]    err_nx;
  logic [IN_W:0]       s;
  logic                load;

  always_comb begin
    s        = {1'b0, hold} + {{(PWM_BITS+1){1'b0}}, err};
    load     = ena && (cnt == '0);
    duty_eff = duty;
    err_nx   = err;
    if (load) begin
      // carry out can only happen on a pathological hold; clamp and drop the residue
      if (s[IN_W]) begin
        duty_eff = '1;
        err_nx   = '0;
      end else begin
        duty_eff = s[IN_W-1 -: PWM_BITS];
        err_nx   = s[ERR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      duty         <= DUTY_MID;
      err          <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt          <= ena ? cnt + 1'b1 : '0;
      duty         <= duty_eff;
      err          <= err_nx;
      pwm_out      <= ena && (cnt < duty_eff);
      period_start <= load;
    end
  end

endmodule

// File: rtl/sid_pwm_dac.sv
// Final audio stage: volume scaling by 4-cycle shift-add multiply, offset-binary
// conversion, and noise-shaped PWM output.
module sid_pwm_dac
  import sid_pkg::*;
#(
  parameter int unsigned IN_W     = SID_IN_W,
  parameter int unsigned PWM_BITS = SID_PWM_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [IN_W-1:0] sample_in,
  input  logic            sample_valid,
  output logic            sample_ready,
  input  logic [3:0]      vol,
  output logic            pwm_out,
  output logic            period_start,
  output logic            overrun
);

  localparam int unsigned ACC_W = IN_W + 4;
  localparam logic [IN_W-1:0] MID = {1'b1, {(IN_W-1){1'b0}}};

  mul_state_t              state, state_nx;
  logic signed [IN_W-1:0]  samp;
  logic signed [ACC_W-1:0] samp_ext;
  logic signed [ACC_W-1:0] acc, acc_nx;
  logic [3:0]              vol_q;
  logic [1:0]              bit_idx;
  logic [IN_W-1:0]         hold;
  logic                    overrun_q;

  always_comb begin
    state_nx = state;
    samp_ext = {{4{samp[IN_W-1]}}, samp};
    acc_nx   = acc + (vol_q[bit_idx] ? (samp_ext <<< bit_idx) : '0);
    case (state)
      ST_IDLE: if (sample_valid && ena) state_nx = ST_MUL;
      ST_MUL:  if (bit_idx == 2'd3) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      samp      <= '0;
      vol_q     <= '0;
      acc       <= '0;
      bit_idx   <= '0;
      hold      <= MID;
      overrun_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE) begin
        if (sample_valid && ena) begin
          samp    <= sample_in;
          vol_q   <= vol;
          acc     <= '0;
          bit_idx <= '0;
        end
      end else begin
        acc     <= acc_nx;
        bit_idx <= bit_idx + 1'b1;
        if (sample_valid) overrun_q <= 1'b1;
        // dropping the low 4 bits of the product divides by 16
        if (bit_idx == 2'd3) hold <= acc_nx[ACC_W-1:4] + MID;
      end
    end
  end

  assign sample_ready = (state == ST_IDLE);
  assign overrun      = overrun_q;

  sid_pwm_core #(
    .IN_W     (IN_W),
    .PWM_BITS (PWM_BITS)
  ) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .hold         (hold),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

endmodule

// File: tb/tb_sid_pwm_dac.sv
// Directed self-checking bench for sid_pwm_dac.
module tb_sid_pwm_dac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  vol;
  logic        pwm_out;
  logic        period_start;
  logic        overrun;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sid_pwm_dac #(
    .IN_W     (16),
    .PWM_BITS (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .vol          (vol),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .overrun      (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a period_start, then counts pwm_out-high clocks over one period.
  task automatic measure(output int high);
    int waited;
    waited = 0;
    high   = 0;
    while (period_start !== 1'b1 && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 600) begin
      high = -1;
      return;
    end
    for (int i = 0; i < 256; i++) begin
      if (pwm_out === 1'b1) high++;
      @(negedge clk);
    end
  endtask

  // Strobes one sample, checks sample_ready stays low 4 clk and the resulting hold.
  task automatic apply(input logic [15:0] smp, input logic [3:0] v,
                       input logic [15:0] exp_hold, input string tag);
    int n;
    sample_in    = smp;
    vol          = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    n = 0;
    while (sample_ready !== 1'b1 && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy"}, n, 4);
    chk({tag, "_hold"}, dut.hold, exp_hold);
    @(negedge clk);
  endtask

  initial begin
    int h, sum, bad_pwm, bad_ps, bad_cnt;
    rst_n        = 1'b0;
    ena          = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    vol          = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ps", period_start, 0);
    chk("rst_ready", sample_ready, 1);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // 1: idle midscale
    measure(h); chk("mid_p0", h, 128);
    measure(h); chk("mid_p1", h, 128);
    chk("mid_overrun", overrun, 0);

    // 2: full positive, vol 15
    apply(16'h7FFF, 4'd15, 16'hF7FF, "pos");
    measure(h); chk("pos_first", h, 247);
    sum = h;
    measure(h); chk("pos_second", h, 248);
    sum += h;
    for (int p = 2; p < 16; p++) begin
      measure(h);
      sum += h;
    end
    chk("pos_sum16", sum, 3967);

    // 3: full negative, then vol 0
    apply(16'h8000, 4'd15, 16'h0800, "neg");
    measure(h); chk("neg_p0", h, 8);
    measure(h); chk("neg_p1", h, 8);
    apply(16'h1234, 4'd0, 16'h8000, "vol0");
    measure(h); chk("vol0_p0", h, 128);

    // 4: second strobe during multiply is dropped
    chk("pre_overrun", overrun, 0);
    sample_in = 16'h4000; vol = 4'd8; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("ovr_ready_c1", sample_ready, 0);
    @(negedge clk);
    sample_in = 16'h7FFF; vol = 4'd15; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("ovr_sticky", overrun, 1);
    @(negedge clk);
    chk("ovr_ready_c4", sample_ready, 0);
    @(negedge clk);
    chk("ovr_ready_c5", sample_ready, 1);
    chk("ovr_hold", dut.hold, 16'hA000);

    // 5: ena low mid-period
    repeat (100) @(negedge clk);
    ena = 1'b0;
    sample_valid = 1'b1;
    bad_pwm = 0; bad_ps = 0; bad_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (pwm_out !== 1'b0) bad_pwm++;
      if (period_start !== 1'b0) bad_ps++;
      if (dut.u_core.cnt !== 8'd0) bad_cnt++;
    end
    chk("dis_pwm", bad_pwm, 0);
    chk("dis_ps", bad_ps, 0);
    chk("dis_cnt", bad_cnt, 0);
    chk("dis_ready", sample_ready, 1);
    chk("dis_hold", dut.hold, 16'hA000);
    ena = 1'b1;
    @(negedge clk);
    chk("reen_ps", period_start, 1);
    measure(h); chk("reen_duty", h, 160);

    // 6: reset during 2nd multiply cycle
    sample_in = 16'h7FFF; vol = 4'd15; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_pwm", pwm_out, 0);
    chk("mrst_ps", period_start, 0);
    chk("mrst_overrun", overrun, 0);
    chk("mrst_ready", sample_ready, 1);
    chk("mrst_hold", dut.hold, 16'h8000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    measure(h); chk("mrst_p0", h, 128);
    measure(h); chk("mrst_p1", h, 128);
    chk("mrst_hold_after", dut.hold, 16'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
